// File: rtl/generator_stream_if.sv
// generator_stream_if: ready/valid/data/last stream channel.
// The master drives valid/data/last and samples ready; the slave is the reverse.
interface generator_stream_if #(
  parameter int DW = 16
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/generator_stream.sv
// generator_stream: ready/valid burst source for bring-up and test traffic.
// Emits bursts of up/down-counter, LFSR or constant words, with a programmable
// ready-qualified gap before every word and start/stop run-time control.
// All outputs come straight from registers.
// Build option: GENERATOR_STREAM_LFSR_EN -- when defined, mode 2 is a Galois
// LFSR using POLY; when undefined, mode 2 behaves exactly like mode 0.
module generator_stream #(
  parameter int            DW   = 16,
  parameter int            CW   = 16,
  parameter int            GW   = 8,
  parameter logic [DW-1:0] POLY = 16'hB400
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          cfg_mode,
  input  logic [DW-1:0]       cfg_seed,
  input  logic [CW-1:0]       cfg_len,
  input  logic [GW-1:0]       cfg_gap,
  generator_stream_if.master  down,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       sent_cnt
);

  typedef enum logic [1:0] {IDLE, GAP, SEND} state_t;

  state_t        state_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] sent_q;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gcnt_q;
  logic [DW-1:0] data_q;
  logic          stop_pend_q;
  logic          valid_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;

  logic          hs_d;
  logic [CW-1:0] sent_d;
  logic [GW-1:0] gcnt_d;
  logic          last_cur_d;
  logic          last_next_d;
  logic [DW-1:0] data_d;

  // Next pattern word after a completed handshake.
  function automatic logic [DW-1:0] advance(input logic [1:0] mode, input logic [DW-1:0] d);
    case (mode)
      2'd1:    return d - DW'(1);
`ifdef GENERATOR_STREAM_LFSR_EN
      2'd2:    return (d >> 1) ^ (d[0] ? POLY : '0);
`endif
      2'd3:    return d;
      default: return d + DW'(1);
    endcase
  endfunction

  // First word of a burst; an all-zero LFSR state would lock up, so use 1.
  function automatic logic [DW-1:0] first_word(input logic [1:0] mode, input logic [DW-1:0] seed);
`ifdef GENERATOR_STREAM_LFSR_EN
    if (mode == 2'd2 && seed == '0) return DW'(1);
`else
    if (mode == 2'd2) return seed;
`endif
    return seed;
  endfunction

`ifndef GENERATOR_STREAM_LFSR_EN
  // The polynomial has no consumer when the LFSR is not built.
  logic unused_poly;
  assign unused_poly = ^POLY;
`endif

  // Handshake detection and next-value helpers for the FSM.
  always_comb begin
    hs_d        = valid_q && down.ready;
    sent_d      = sent_q + CW'(1);
    gcnt_d      = gcnt_q + GW'(1);
    last_cur_d  = (len_q != '0) && (sent_q == len_q - CW'(1));
    last_next_d = (len_q != '0) && (sent_d == len_q - CW'(1));
    data_d      = advance(mode_q, data_q);
  end

  // Burst FSM with registered stream, status and counter outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      len_q       <= '0;
      sent_q      <= '0;
      gap_q       <= '0;
      gcnt_q      <= '0;
      data_q      <= '0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            mode_q      <= cfg_mode;
            len_q       <= cfg_len;
            gap_q       <= cfg_gap;
            data_q      <= first_word(cfg_mode, cfg_seed);
            sent_q      <= '0;
            gcnt_q      <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cfg_gap == '0) begin
              state_q <= SEND;
              valid_q <= 1'b1;
              last_q  <= (cfg_len == CW'(1));
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (stop) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (down.ready) begin
            if (gcnt_d == gap_q) begin
              gcnt_q  <= '0;
              state_q <= SEND;
              valid_q <= 1'b1;
              last_q  <= last_cur_d;
            end else begin
              gcnt_q <= gcnt_d;
            end
          end
        end
        SEND: begin
          if (hs_d) begin
            sent_q <= sent_d;
            data_q <= data_d;
            if (last_q || stop_pend_q || stop) begin
              state_q     <= IDLE;
              valid_q     <= 1'b0;
              last_q      <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              stop_pend_q <= 1'b0;
            end else if (gap_q != '0) begin
              state_q <= GAP;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              last_q <= last_next_d;
            end
          end else if (stop) begin
            stop_pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign down.valid = valid_q;
  assign down.data  = data_q;
  assign down.last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_cnt   = sent_q;

endmodule

// File: tb/tb_generator_stream.sv
// tb_generator_stream: self-checking bench for generator_stream.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_generator_stream;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [DW-1:0] cfg_seed = '0;
  logic [CW-1:0] cfg_len = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic          ready = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_cnt;

  int checks = 0;
  int failures = 0;

  generator_stream_if #(.DW(DW)) dif ();
  assign dif.ready = ready;

  generator_stream #(.DW(DW), .CW(CW), .GW(GW), .POLY(16'hB400)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .down(dif), .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference: k-th word of a burst from the pattern rules.
  function automatic logic [15:0] model_word(input logic [1:0] m, input logic [15:0] s, input int k);
    logic [15:0] x;
    x = s;
    case (m)
      2'd1: x = s - 16'(k);
      2'd3: x = s;
      2'd2: begin
`ifdef GENERATOR_STREAM_LFSR_EN
        if (x == 16'd0) x = 16'd1;
        for (int i = 0; i < k; i++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
`else
        x = s + 16'(k);
`endif
      end
      default: x = s + 16'(k);
    endcase
    return x;
  endfunction

  // Pulse start for one cycle with the given configuration (called at a negedge).
  task automatic do_start(input logic [1:0] m, input logic [15:0] s, input logic [15:0] l, input logic [7:0] g);
    cfg_mode = m; cfg_seed = s; cfg_len = l; cfg_gap = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (dif.valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", dif.valid); end
    checks++; if (dif.data !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0000", dif.data); end
    checks++; if (dif.last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", dif.last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (sent_cnt !== 16'h0) begin failures++; $display("FAIL rst_sent got=%0d exp=0", sent_cnt); end
  endtask

  task automatic test_up_counter;
    ready = 1'b1;
    do_start(2'd0, 16'd5, 16'd4, 8'd0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (dif.valid !== 1'b1) begin failures++; $display("FAIL up_valid k=%0d got=%b exp=1", k, dif.valid); end
      checks++; if (dif.data !== 16'(5 + k)) begin failures++; $display("FAIL up_data k=%0d got=%h exp=%h", k, dif.data, 16'(5 + k)); end
      checks++; if (dif.last !== (k == 3)) begin failures++; $display("FAIL up_last k=%0d got=%b exp=%b", k, dif.last, (k == 3)); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL up_busy k=%0d got=%b exp=1", k, busy); end
      @(negedge clk);
    end
    checks++; if (dif.valid !== 1'b0) begin failures++; $display("FAIL up_end_valid got=%b exp=0", dif.valid); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL up_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL up_end_busy got=%b exp=0", busy); end
    checks++; if (sent_cnt !== 16'd4) begin failures++; $display("FAIL up_sent got=%0d exp=4", sent_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL up_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_gap_backpressure;
    int k, gcnt, c;
    logic pv, pr, pl, got_done;
    logic [15:0] pd;
    k = 0; gcnt = 0; pv = 0; pr = 0; pl = 0; pd = '0; got_done = 0;
    ready = 1'b0;
    do_start(2'd3, 16'hA5A5, 16'd2, 8'd3);
    for (c = 0; c < 60 && !got_done; c++) begin
      if (dif.valid && !pv) begin
        checks++; if (gcnt !== 3) begin failures++; $display("FAIL gap_count k=%0d got=%0d exp=3", k, gcnt); end
        gcnt = 0;
      end
      if (dif.valid && pv && !pr) begin
        checks++; if (dif.data !== pd) begin failures++; $display("FAIL gap_stable k=%0d got=%h exp=%h", k, dif.data, pd); end
      end
      if (done) begin
        got_done = 1;
        checks++; if (k !== 2) begin failures++; $display("FAIL gap_words got=%0d exp=2", k); end
        checks++; if (sent_cnt !== 16'd2) begin failures++; $display("FAIL gap_sent got=%0d exp=2", sent_cnt); end
      end else begin
        pv = dif.valid; pd = dif.data; pl = dif.last;
        ready = (c % 2 == 0);
        pr = ready;
        if (dif.valid && ready) begin
          checks++; if (dif.data !== 16'hA5A5) begin failures++; $display("FAIL gap_data k=%0d got=%h exp=a5a5", k, dif.data); end
          checks++; if (dif.last !== (k == 1)) begin failures++; $display("FAIL gap_last k=%0d got=%b exp=%b", k, dif.last, (k == 1)); end
          k++;
        end
        if (busy && !dif.valid && ready) gcnt++;
        @(negedge clk);
      end
    end
    if (!got_done) begin checks++; failures++; $display("FAIL gap_timeout got=no_done exp=done"); end
    ready = 1'b0;
  endtask

  task automatic test_down_wrap;
    logic [15:0] ex [0:2];
    ex[0] = 16'h0001; ex[1] = 16'h0000; ex[2] = 16'hFFFF;
    ready = 1'b1;
    do_start(2'd1, 16'd1, 16'd3, 8'd0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dif.data !== ex[k]) begin failures++; $display("FAIL down_data k=%0d got=%h exp=%h", k, dif.data, ex[k]); end
      checks++; if (dif.last !== (k == 2)) begin failures++; $display("FAIL down_last k=%0d got=%b exp=%b", k, dif.last, (k == 2)); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL down_done got=%b exp=1", done); end
  endtask

  task automatic test_lfsr;
    logic [15:0] ex [0:2];
`ifdef GENERATOR_STREAM_LFSR_EN
    ex[0] = 16'h0001; ex[1] = 16'hB400; ex[2] = 16'h5A00;
`else
    ex[0] = 16'h0000; ex[1] = 16'h0001; ex[2] = 16'h0002;
`endif
    ready = 1'b1;
    do_start(2'd2, 16'd0, 16'd3, 8'd0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dif.valid !== 1'b1 || dif.data !== ex[k]) begin failures++; $display("FAIL lfsr_data k=%0d got=%h/%b exp=%h/1", k, dif.data, dif.valid, ex[k]); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL lfsr_done got=%b exp=1", done); end
  endtask

  task automatic test_stop_send;
    ready = 1'b0;
    do_start(2'd0, 16'h0100, 16'd0, 8'd0);
    checks++; if (dif.valid !== 1'b1 || dif.data !== 16'h0100) begin failures++; $display("FAIL stop_first got=%h/%b exp=0100/1", dif.data, dif.valid); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (dif.valid !== 1'b1) begin failures++; $display("FAIL stop_hold_valid c=%0d got=%b exp=1", c, dif.valid); end
      checks++; if (dif.data !== 16'h0100) begin failures++; $display("FAIL stop_hold_data c=%0d got=%h exp=0100", c, dif.data); end
      checks++; if (dif.last !== 1'b0) begin failures++; $display("FAIL stop_last c=%0d got=%b exp=0", c, dif.last); end
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (dif.valid !== 1'b0) begin failures++; $display("FAIL stop_end_valid got=%b exp=0", dif.valid); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stop_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
    checks++; if (sent_cnt !== 16'd1) begin failures++; $display("FAIL stop_sent got=%0d exp=1", sent_cnt); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (dif.valid !== 1'b0 || dif.last !== 1'b0) begin failures++; $display("FAIL stop_after c=%0d got=%b%b exp=00", c, dif.valid, dif.last); end
    end
    ready = 1'b0;
  endtask

  task automatic test_stop_gap;
    ready = 1'b0;
    do_start(2'd0, 16'd0, 16'd0, 8'd5);
    checks++; if (busy !== 1'b1 || dif.valid !== 1'b0) begin failures++; $display("FAIL sgap_busy got=%b%b exp=10", busy, dif.valid); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sgap_idle got=%b exp=0", busy); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL sgap_done got=%b exp=1", done); end
    checks++; if (dif.valid !== 1'b0) begin failures++; $display("FAIL sgap_valid got=%b exp=0", dif.valid); end
    @(negedge clk);
  endtask

  task automatic test_start_stop_same;
    ready = 1'b1;
    stop = 1'b1;
    do_start(2'd0, 16'd9, 16'd2, 8'd0);
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || dif.valid !== 1'b0) begin failures++; $display("FAIL ss_idle got=%b%b exp=00", busy, dif.valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ss_done got=%b exp=0", done); end
  endtask

  task automatic test_async_reset;
    ready = 1'b1;
    do_start(2'd0, 16'h1234, 16'd0, 8'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (dif.valid !== 1'b0 || dif.data !== 16'h0 || dif.last !== 1'b0) begin failures++; $display("FAIL arst_stream got=%b/%h/%b exp=0/0000/0", dif.valid, dif.data, dif.last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sent_cnt !== 16'h0) begin failures++; $display("FAIL arst_status got=%b/%b/%0d exp=0/0/0", busy, done, sent_cnt); end
    @(negedge clk);
    rst = 1'b1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_nodone got=%b exp=0", done); end
    @(negedge clk);
    ready = 1'b0;
    do_start(2'd0, 16'h0040, 16'd0, 8'd0);
    checks++; if (sent_cnt !== 16'd0 || dif.data !== 16'h0040 || dif.valid !== 1'b1) begin failures++; $display("FAIL arst_fresh got=%0d/%h/%b exp=0/0040/1", sent_cnt, dif.data, dif.valid); end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (sent_cnt !== 16'd1 || dif.data !== 16'h0041) begin failures++; $display("FAIL arst_next got=%0d/%h exp=1/0041", sent_cnt, dif.data); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    ready = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL arst_stop got=%b/%b exp=0/1", busy, done); end
    @(negedge clk);
  endtask

  task automatic test_random_bursts;
    logic [1:0]  m;
    logic [15:0] s, l, pd;
    logic [7:0]  g;
    logic        pv, pr, got_done;
    int          k, gcnt;
    for (int b = 0; b < 25; b++) begin
      m = 2'($urandom_range(0, 3));
      s = 16'($urandom);
      l = 16'($urandom_range(1, 6));
      g = 8'($urandom_range(0, 3));
      do_start(m, s, l, g);
      k = 0; gcnt = 0; pv = 0; pr = 0; pd = '0; got_done = 0;
      for (int c = 0; c < 300 && !got_done; c++) begin
        if (dif.valid && !pv) begin
          checks++; if (gcnt !== int'(g)) begin failures++; $display("FAIL rnd_gap b=%0d k=%0d got=%0d exp=%0d", b, k, gcnt, g); end
          gcnt = 0;
        end
        if (dif.valid && pv && !pr) begin
          checks++; if (dif.data !== pd) begin failures++; $display("FAIL rnd_stable b=%0d k=%0d got=%h exp=%h", b, k, dif.data, pd); end
        end
        if (done) begin
          got_done = 1;
          checks++; if (k !== int'(l) || sent_cnt !== l) begin failures++; $display("FAIL rnd_count b=%0d got=%0d/%0d exp=%0d", b, k, sent_cnt, l); end
          checks++; if (busy !== 1'b0 || dif.valid !== 1'b0) begin failures++; $display("FAIL rnd_idle b=%0d got=%b%b exp=00", b, busy, dif.valid); end
        end else begin
          pv = dif.valid; pd = dif.data;
          ready = 1'($urandom_range(0, 1));
          pr = ready;
          cfg_mode = 2'($urandom); cfg_seed = 16'($urandom);
          cfg_len = 16'($urandom); cfg_gap = 8'($urandom);
          if (dif.valid && ready) begin
            checks++; if (dif.data !== model_word(m, s, k)) begin failures++; $display("FAIL rnd_data b=%0d m=%0d k=%0d got=%h exp=%h", b, m, k, dif.data, model_word(m, s, k)); end
            checks++; if (dif.last !== (k == int'(l) - 1)) begin failures++; $display("FAIL rnd_last b=%0d k=%0d got=%b exp=%b", b, k, dif.last, (k == int'(l) - 1)); end
            k++;
          end
          if (busy && !dif.valid && ready) gcnt++;
          @(negedge clk);
        end
      end
      if (!got_done) begin checks++; failures++; $display("FAIL rnd_timeout b=%0d got=no_done exp=done", b); end
    end
    ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_up_counter();
    test_gap_backpressure();
    test_down_wrap();
    test_lfsr();
    test_stop_send();
    test_stop_gap();
    test_start_stop_same();
    test_async_reset();
    test_random_bursts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/generator_stream.md
# generator_stream

Parametrised ready/valid stream source for testbench and bring-up traffic. It emits bursts of configurable length and data pattern (up/down counter, LFSR or constant), inserting a programmable, ready-qualified gap before every word. It sits at the head of a datapath under test, driving its downstream valid/ready/data/last channel. Start/stop control lets sequencers or firmware shape traffic at run time.

## Interface
- DW, 16: data width.
- CW, 16: width of burst length and sent-word counter.
- GW, 8: width of gap configuration.
- POLY, 16'hB400: Galois LFSR tap mask, DW bits wide.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- stop  in  1  request to end the current burst early.
- cfg_mode  in  2  pattern: 0 up-counter, 1 down-counter, 2 LFSR, 3 constant.
- cfg_seed  in  DW  first data word.
- cfg_len  in  CW  words per burst; 0 = continuous until stop.
- cfg_gap  in  GW  ready-qualified idle cycles before each word.
- down_ready  in  1  downstream ready.
- down_valid  out  1  data valid.
- down_data  out  DW  data word.
- down_last  out  1  marks the final word of a length-terminated burst.
- busy  out  1  high in GAP or SEND.
- done  out  1  one-cycle pulse when a burst ends.
- sent_cnt  out  CW  handshakes completed in the current or last burst.

## Operation
- FSM states are IDLE, GAP and SEND. Gap counter is GW bits wide.
- IDLE:
  - On start with stop=0, latch cfg_* and load the data register with cfg_seed. In LFSR mode a zero seed is replaced by 1.
  - Clear sent_cnt and the gap counter.
  - Go to SEND if cfg_gap==0, otherwise go to GAP.
- GAP:
  - The gap counter increments only in cycles where down_ready=1.
  - When the count reaches cfg_gap, clear it and go to SEND.
- SEND:
  - down_valid=1. down_data and down_last hold stable until handshake (down_valid && down_ready).
  - On handshake, sent_cnt increments and the data register advances:
    - mode 0: +1 mod 2^DW.
    - mode 1: −1 mod 2^DW.
    - mode 2: Galois right shift; if the shifted-out LSB is 1, XOR with POLY.
    - mode 3: unchanged.
  - Next state after handshake: IDLE if the word was last or stop is pending; else GAP if gap>0; else stay in SEND.
- down_last = 1 in SEND when len≠0 and sent_cnt==len−1.
- Stop handling:
  - Stop in GAP: go to IDLE next cycle and pulse done.
  - Stop in SEND: set stop_pend. The current word still completes its handshake; valid never drops without a handshake. The burst then ends, and down_last is not asserted for stop-ended bursts.
- start while busy is ignored. start and stop in the same IDLE cycle: stop wins and no burst begins.
- Continuous mode (len=0): sent_cnt wraps 2^CW−1 → 0, and down_last is never asserted.
- cfg_* changes during a burst have no effect until the next start.

## Timing
- Reset values: down_valid 0, down_data 0, down_last 0, busy 0, done 0, sent_cnt 0, state IDLE.
- Reset asserted mid-burst aborts immediately. done is not pulsed.
- start → down_valid = 1 cycle when gap=0. With gap>0, down_valid rises 1 cycle after the gap-th ready cycle in GAP.
- Back-to-back words at 1/cycle when gap=0 and down_ready is held high.
- done pulses the cycle after the terminating handshake (or the cycle after a stop in GAP), coincident with busy falling.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- GENERATOR_STREAM_LFSR_EN
  - Defined: mode 2 is LFSR as specified, and POLY is used.
  - Undefined: no LFSR logic is built, and mode 2 behaves exactly as mode 0 (up-counter, no zero-seed substitution).

## Test plan
- Up-counter burst: mode 0, seed 5, len 4, gap 0, ready high → data 5,6,7,8 on consecutive cycles; last on 8; done one cycle later; sent_cnt=4.
- Gap with backpressure: mode 3, seed 0xA5A5, len 2, gap 3, ready toggling 1010… → each word valid only after 3 ready-high cycles in GAP; data stable while ready=0.
- Down-counter wrap: mode 1, seed 1, len 3 → 1, 0, 0xFFFF; last on 0xFFFF.
- LFSR (macro defined): seed 0, len 3 → 0x0001, 0xB400, 0x5A00. Macro undefined, same stimulus → 0, 1, 2.
- Stop in SEND with ready low: len 0, stop pulsed while valid=1 → valid holds until ready; after the handshake, no further words, last stays 0, done pulses.
- Async reset: assert rst low during SEND → all outputs 0 immediately; start after release begins a fresh burst with sent_cnt from 0.
